// File: rtl/ctrl_code_encode.sv
// Serializes one 22-byte control-code frame onto the FPRI/code pair (FPRI pulse, then 176 bits MSB-first).
// Latency: FPRI rises 1 cycle after an accepted start; done pulses FPRI_HIGH+176*BIT_CYC+TAIL_CYC+1 cycles after it.
// Backpressure: start is accepted only while busy=0 (IDLE or DONE); requests while busy are dropped, not queued.
module ctrl_code_encode #(
    parameter int unsigned BIT_CYC   = 4,
    parameter int unsigned FPRI_HIGH = 8,
    parameter int unsigned TAIL_CYC  = 8
) (
    input  logic        glb_100M,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  work_mode,
    input  logic [7:0]  ver_code,
    input  logic [7:0]  wave_code,
    input  logic [7:0]  fre_code,
    input  logic [15:0] pri_code,
    input  logic [7:0]  hor1_code,
    input  logic [7:0]  hor2_code,
    input  logic [7:0]  hor3_code,
    input  logic [7:0]  pulse_mode,
    input  logic [7:0]  monitor_addr,
    input  logic [7:0]  monitor_mode,
    input  logic [15:0] hor_phase_R,
    input  logic [15:0] ver_phase_R,
    input  logic [15:0] hor_phase_T,
    input  logic [15:0] ver_phase_T,
    output logic        FPRI,
    output logic        code,
    output logic        busy,
    output logic        done
);

    localparam int unsigned BW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

    localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_CYC - 1);
    localparam logic [7:0]    HEAD_LAST = 8'(FPRI_HIGH - 1);
    localparam logic [7:0]    TAIL_LAST = 8'(TAIL_CYC - 1);
    localparam logic [7:0]    IDX_LAST  = 8'd175;

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        SHIFT,
        TAIL,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [BW-1:0]  bit_cnt;
    logic [BW-1:0]  bit_cnt_nxt;
    logic [7:0]     idx;
    logic [7:0]     idx_nxt;
    logic [7:0]     phase_cnt;
    logic [7:0]     phase_cnt_nxt;
    logic [175:0]   shadow;
    logic [175:0]   shadow_nxt;
    logic [175:0]   frame_img;
    logic           fpri_nxt;
    logic           code_nxt;
    logic           busy_nxt;
    logic           done_nxt;

    // Transmit order is MSB of this vector first; 16-bit fields go low byte first.
    assign frame_img = {
        8'hAA,              8'h55,
        work_mode,          ver_code,
        wave_code,          fre_code,
        pri_code[7:0],      pri_code[15:8],
        hor1_code,          hor2_code,
        hor3_code,          pulse_mode,
        monitor_addr,       monitor_mode,
        hor_phase_R[7:0],   hor_phase_R[15:8],
        ver_phase_R[7:0],   ver_phase_R[15:8],
        hor_phase_T[7:0],   hor_phase_T[15:8],
        ver_phase_T[7:0],   ver_phase_T[15:8]
    };

    // Outputs are computed for the next cycle and registered, so FPRI/code never glitch.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        idx_nxt       = idx;
        phase_cnt_nxt = phase_cnt;
        shadow_nxt    = shadow;
        fpri_nxt      = 1'b0;
        code_nxt      = 1'b0;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt     = HEAD;
                    shadow_nxt    = frame_img;
                    phase_cnt_nxt = 8'd0;
                    fpri_nxt      = 1'b1;
                    busy_nxt      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end

            HEAD: begin
                busy_nxt = 1'b1;
                if (phase_cnt == HEAD_LAST) begin
                    state_nxt   = SHIFT;
                    bit_cnt_nxt = '0;
                    idx_nxt     = 8'd0;
                    code_nxt    = shadow[175];
                end else begin
                    phase_cnt_nxt = phase_cnt + 8'd1;
                    fpri_nxt      = 1'b1;
                end
            end

            SHIFT: begin
                busy_nxt = 1'b1;
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_nxt = '0;
                    if (idx == IDX_LAST) begin
                        state_nxt     = TAIL;
                        phase_cnt_nxt = 8'd0;
                    end else begin
                        idx_nxt    = idx + 8'd1;
                        shadow_nxt = {shadow[174:0], 1'b0};
                        code_nxt   = shadow[174];
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    code_nxt    = shadow[175];
                end
            end

            TAIL: begin
                if (phase_cnt == TAIL_LAST) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    phase_cnt_nxt = phase_cnt + 8'd1;
                    busy_nxt      = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge glb_100M or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            idx       <= 8'd0;
            phase_cnt <= 8'd0;
            shadow    <= '0;
            FPRI      <= 1'b0;
            code      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            idx       <= idx_nxt;
            phase_cnt <= phase_cnt_nxt;
            shadow    <= shadow_nxt;
            FPRI      <= fpri_nxt;
            code      <= code_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule
